// File: rtl/rob_if.sv
// Issue, writeback, operand-query and retire signals between the pipeline and the reorder buffer.
interface rob_if #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 4
);
  logic                 iss_en_in;
  logic [4:0]           iss_dest_in;
  logic                 iss_is_branch_in;
  logic                 iss_is_store_in;
  logic                 iss_pred_taken_in;
  logic [DATA_W-1:0]    iss_alt_pc_in;
  logic                 iss_ready_in;
  logic [DATA_W-1:0]    iss_val_in;
  logic [ROB_IDX_W-1:0] tail_idx_out;
  logic                 full_out;

  logic                 alu_en_in;
  logic [ROB_IDX_W-1:0] alu_idx_in;
  logic [DATA_W-1:0]    alu_val_in;
  logic                 alu_taken_in;
  logic                 lsb_en_in;
  logic [ROB_IDX_W-1:0] lsb_idx_in;
  logic [DATA_W-1:0]    lsb_val_in;

  logic [ROB_IDX_W-1:0] rs1_dep_in;
  logic [ROB_IDX_W-1:0] rs2_dep_in;
  logic                 rs1_busy_out;
  logic [DATA_W-1:0]    rs1_val_out;
  logic                 rs2_busy_out;
  logic [DATA_W-1:0]    rs2_val_out;

  logic                 commit_en_out;
  logic [ROB_IDX_W-1:0] commit_idx_out;
  logic [4:0]           commit_dest_out;
  logic [DATA_W-1:0]    commit_val_out;
  logic                 store_commit_out;
  logic [ROB_IDX_W-1:0] store_commit_idx_out;
  logic                 roll_back_out;
  logic [DATA_W-1:0]    roll_back_pc_out;

  modport master (
    output iss_en_in, iss_dest_in, iss_is_branch_in, iss_is_store_in, iss_pred_taken_in,
           iss_alt_pc_in, iss_ready_in, iss_val_in,
           alu_en_in, alu_idx_in, alu_val_in, alu_taken_in, lsb_en_in, lsb_idx_in, lsb_val_in,
           rs1_dep_in, rs2_dep_in,
    input  tail_idx_out, full_out, rs1_busy_out, rs1_val_out, rs2_busy_out, rs2_val_out,
           commit_en_out, commit_idx_out, commit_dest_out, commit_val_out,
           store_commit_out, store_commit_idx_out, roll_back_out, roll_back_pc_out
  );

  modport slave (
    input  iss_en_in, iss_dest_in, iss_is_branch_in, iss_is_store_in, iss_pred_taken_in,
           iss_alt_pc_in, iss_ready_in, iss_val_in,
           alu_en_in, alu_idx_in, alu_val_in, alu_taken_in, lsb_en_in, lsb_idx_in, lsb_val_in,
           rs1_dep_in, rs2_dep_in,
    output tail_idx_out, full_out, rs1_busy_out, rs1_val_out, rs2_busy_out, rs2_val_out,
           commit_en_out, commit_idx_out, commit_dest_out, commit_val_out,
           store_commit_out, store_commit_idx_out, roll_back_out, roll_back_pc_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags issued instructions, gathers ALU/LSB results,
// retires in program order and flushes on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int DATA_W   = 32
) (
  input logic  clk,
  input logic  rst_n_in,
  input logic  rdy_in,
  rob_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;

  logic [4:0]          dest_q   [ROB_SIZE];
  logic [DATA_W-1:0]   val_q    [ROB_SIZE];
  logic [DATA_W-1:0]   alt_pc_q [ROB_SIZE];
  logic [ROB_SIZE-1:0] is_branch_q, is_store_q, pred_q, taken_q;

  logic                commit_en_q, commit_en_d;
  logic [IDX_W-1:0]    commit_idx_q, commit_idx_d;
  logic [4:0]          commit_dest_q, commit_dest_d;
  logic [DATA_W-1:0]   commit_val_q, commit_val_d;
  logic                store_commit_q, store_commit_d;
  logic [IDX_W-1:0]    store_idx_q, store_idx_d;
  logic                roll_back_q, roll_back_d;
  logic [DATA_W-1:0]   roll_back_pc_q, roll_back_pc_d;

  logic full, flush, do_issue, alu_wb, lsb_wb, do_commit, mispred;

  // Result-bus bypass first (ALU over LSB), then the stored entry.
  function automatic logic [DATA_W:0] query(
    input logic [IDX_W-1:0]  dep,
    input logic              alu_en,
    input logic [IDX_W-1:0]  alu_idx,
    input logic [DATA_W-1:0] alu_val,
    input logic              lsb_en,
    input logic [IDX_W-1:0]  lsb_idx,
    input logic [DATA_W-1:0] lsb_val,
    input logic              ent_ready,
    input logic [DATA_W-1:0] ent_val
  );
    if (alu_en && alu_idx == dep)      return {1'b0, alu_val};
    else if (lsb_en && lsb_idx == dep) return {1'b0, lsb_val};
    else if (ent_ready)                return {1'b0, ent_val};
    else                               return {1'b1, {DATA_W{1'b0}}};
  endfunction

  assign full  = (count_q == CNT_W'(ROB_SIZE));
  assign flush = roll_back_q;

  always_comb begin
    do_issue  = bus.iss_en_in && !full && !flush;
    alu_wb    = bus.alu_en_in && busy_q[bus.alu_idx_in] && !flush;
    lsb_wb    = bus.lsb_en_in && busy_q[bus.lsb_idx_in] && !flush;
    do_commit = busy_q[head_q] && ready_q[head_q] && !flush;
    mispred   = is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

    busy_d         = busy_q;
    ready_d        = ready_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_en_d    = 1'b0;
    commit_idx_d   = '0;
    commit_dest_d  = '0;
    commit_val_d   = '0;
    store_commit_d = 1'b0;
    store_idx_d    = '0;
    roll_back_d    = 1'b0;
    roll_back_pc_d = '0;

    if (alu_wb) ready_d[bus.alu_idx_in] = 1'b1;
    if (lsb_wb) ready_d[bus.lsb_idx_in] = 1'b1;

    if (do_issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = bus.iss_ready_in;
      tail_d          = tail_q + IDX_W'(1);
    end

    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + IDX_W'(1);
      if (mispred) begin
        roll_back_d    = 1'b1;
        roll_back_pc_d = alt_pc_q[head_q];
      end else if (is_store_q[head_q]) begin
        store_commit_d = 1'b1;
        store_idx_d    = head_q;
      end else begin
        commit_en_d   = 1'b1;
        commit_idx_d  = head_q;
        commit_dest_d = dest_q[head_q];
        commit_val_d  = val_q[head_q];
      end
    end

    case ({do_issue, do_commit})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_idx_q   <= '0;
      commit_dest_q  <= '0;
      commit_val_q   <= '0;
      store_commit_q <= 1'b0;
      store_idx_q    <= '0;
      roll_back_q    <= 1'b0;
      roll_back_pc_q <= '0;
    end else if (rdy_in) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      commit_en_q    <= commit_en_d;
      commit_idx_q   <= commit_idx_d;
      commit_dest_q  <= commit_dest_d;
      commit_val_q   <= commit_val_d;
      store_commit_q <= store_commit_d;
      store_idx_q    <= store_idx_d;
      roll_back_q    <= roll_back_d;
      roll_back_pc_q <= roll_back_pc_d;
    end
  end

  // Entry payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy_in) begin
      if (do_issue) begin
        dest_q[tail_q]      <= bus.iss_dest_in;
        val_q[tail_q]       <= bus.iss_val_in;
        alt_pc_q[tail_q]    <= bus.iss_alt_pc_in;
        is_branch_q[tail_q] <= bus.iss_is_branch_in;
        is_store_q[tail_q]  <= bus.iss_is_store_in;
        pred_q[tail_q]      <= bus.iss_pred_taken_in;
        // A branch resolved at issue is treated as correctly predicted.
        taken_q[tail_q]     <= bus.iss_pred_taken_in;
      end
      if (lsb_wb) val_q[bus.lsb_idx_in] <= bus.lsb_val_in;
      if (alu_wb) begin
        val_q[bus.alu_idx_in]   <= bus.alu_val_in;
        taken_q[bus.alu_idx_in] <= bus.alu_taken_in;
      end
    end
  end

  assign {bus.rs1_busy_out, bus.rs1_val_out} = query(bus.rs1_dep_in,
      bus.alu_en_in, bus.alu_idx_in, bus.alu_val_in, bus.lsb_en_in, bus.lsb_idx_in, bus.lsb_val_in,
      ready_q[bus.rs1_dep_in], val_q[bus.rs1_dep_in]);
  assign {bus.rs2_busy_out, bus.rs2_val_out} = query(bus.rs2_dep_in,
      bus.alu_en_in, bus.alu_idx_in, bus.alu_val_in, bus.lsb_en_in, bus.lsb_idx_in, bus.lsb_val_in,
      ready_q[bus.rs2_dep_in], val_q[bus.rs2_dep_in]);

  assign bus.tail_idx_out         = tail_q;
  assign bus.full_out             = full;
  assign bus.commit_en_out        = commit_en_q;
  assign bus.commit_idx_out       = commit_idx_q;
  assign bus.commit_dest_out      = commit_dest_q;
  assign bus.commit_val_out       = commit_val_q;
  assign bus.store_commit_out     = store_commit_q;
  assign bus.store_commit_idx_out = store_idx_q;
  assign bus.roll_back_out        = roll_back_q;
  assign bus.roll_back_pc_out     = roll_back_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: retire events are queued at issue and
// compared in order as commit/store/rollback pulses appear.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  always #5 clk = ~clk;

  rob_if #(.DATA_W(32), .ROB_IDX_W(4)) bus ();

  reorder_buffer #(.ROB_SIZE(16), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bus      (bus)
  );

  typedef struct packed {
    logic [1:0]  kind;  // 1 commit, 2 store, 3 rollback
    logic [3:0]  idx;
    logic [4:0]  dest;
    logic [31:0] val;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] mtail;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin : mon
    int  n;
    ev_t got;
    ev_t ex;
    if (rst_n) begin
      n   = int'(bus.commit_en_out) + int'(bus.store_commit_out) + int'(bus.roll_back_out);
      got = '0;
      if (bus.commit_en_out) begin
        got.kind = 2'd1; got.idx = bus.commit_idx_out;
        got.dest = bus.commit_dest_out; got.val = bus.commit_val_out;
      end else if (bus.store_commit_out) begin
        got.kind = 2'd2; got.idx = bus.store_commit_idx_out;
      end else if (bus.roll_back_out) begin
        got.kind = 2'd3; got.val = bus.roll_back_pc_out;
      end
      if (n > 0) begin
        chk("retire_onehot", 64'(n <= 1), 64'd1);
        if (exp_q.size() == 0) chk("unexpected_retire", 64'(got), 64'd0);
        else begin
          ex = exp_q.pop_front();
          chk("retire_event", 64'(got), 64'(ex));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    bus.iss_en_in = 0; bus.iss_dest_in = '0; bus.iss_is_branch_in = 0; bus.iss_is_store_in = 0;
    bus.iss_pred_taken_in = 0; bus.iss_alt_pc_in = '0; bus.iss_ready_in = 0; bus.iss_val_in = '0;
    bus.alu_en_in = 0; bus.alu_idx_in = '0; bus.alu_val_in = '0; bus.alu_taken_in = 0;
    bus.lsb_en_in = 0; bus.lsb_idx_in = '0; bus.lsb_val_in = '0;
    bus.rs1_dep_in = '0; bus.rs2_dep_in = '0;
  endtask

  task automatic set_iss(input logic [4:0] dest, input logic br, input logic st, input logic pred,
                         input logic [31:0] alt, input logic rd, input logic [31:0] v);
    bus.iss_en_in = 1; bus.iss_dest_in = dest; bus.iss_is_branch_in = br; bus.iss_is_store_in = st;
    bus.iss_pred_taken_in = pred; bus.iss_alt_pc_in = alt; bus.iss_ready_in = rd; bus.iss_val_in = v;
  endtask

  // kind 0 = entry expected never to retire (flushed)
  task automatic issue(input logic [4:0] dest, input logic br, input logic st, input logic pred,
                       input logic [31:0] alt, input logic rd, input logic [31:0] v,
                       input logic [1:0] kind, input logic [31:0] ev_val);
    ev_t e;
    if (kind != 2'd0) begin
      e.kind = kind;
      e.idx  = (kind == 2'd3) ? 4'd0 : mtail;
      e.dest = (kind == 2'd1) ? dest : 5'd0;
      e.val  = (kind == 2'd2) ? 32'd0 : ev_val;
      exp_q.push_back(e);
    end
    set_iss(dest, br, st, pred, alt, rd, v);
    tick();
    bus.iss_en_in = 0;
    mtail = mtail + 4'd1;
  endtask

  task automatic alu_wb(input logic [3:0] idx, input logic [31:0] v, input logic tk);
    bus.alu_en_in = 1; bus.alu_idx_in = idx; bus.alu_val_in = v; bus.alu_taken_in = tk;
    tick();
    bus.alu_en_in = 0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] bidx;
    logic [3:0] t;
    bit         found;

    clr();
    rdy   = 1;
    rst_n = 0;
    mtail = '0;
    tick();
    tick();
    chk("rst_commit_en", 64'(bus.commit_en_out), 0);
    chk("rst_store", 64'(bus.store_commit_out), 0);
    chk("rst_rollback", 64'(bus.roll_back_out), 0);
    chk("rst_commit_val", 64'(bus.commit_val_out), 0);
    chk("rst_tail", 64'(bus.tail_idx_out), 0);
    chk("rst_full", 64'(bus.full_out), 0);
    rst_n = 1;
    tick();

    // Out-of-order writeback, in-order retirement
    issue(5'd1, 0, 0, 0, 0, 0, 0, 2'd1, 32'h00);
    issue(5'd2, 0, 0, 0, 0, 0, 0, 2'd1, 32'h11);
    issue(5'd3, 0, 0, 0, 0, 0, 0, 2'd1, 32'h22);
    chk("tail_after3", 64'(bus.tail_idx_out), 3);
    bus.rs1_dep_in = 4'd1;
    #1;
    chk("q_pending_busy", 64'(bus.rs1_busy_out), 1);
    chk("q_pending_val", 64'(bus.rs1_val_out), 0);
    alu_wb(4'd2, 32'h22, 0);
    bus.rs2_dep_in = 4'd2;
    #1;
    chk("q_ready_busy", 64'(bus.rs2_busy_out), 0);
    chk("q_ready_val", 64'(bus.rs2_val_out), 32'h22);
    alu_wb(4'd0, 32'h00, 0);
    alu_wb(4'd1, 32'h11, 0);
    clr();
    drain(10);

    // Same-cycle bypass, ALU over LSB
    bus.alu_en_in = 1; bus.alu_idx_in = 4'd5; bus.alu_val_in = 32'hDEAD;
    bus.lsb_en_in = 1; bus.lsb_idx_in = 4'd5; bus.lsb_val_in = 32'hBEEF;
    bus.rs1_dep_in = 4'd5; bus.rs2_dep_in = 4'd5;
    #1;
    chk("bypass_busy", 64'(bus.rs1_busy_out), 0);
    chk("bypass_alu_val", 64'(bus.rs1_val_out), 32'hDEAD);
    bus.alu_en_in = 0;
    #1;
    chk("bypass_lsb_val", 64'(bus.rs2_val_out), 32'hBEEF);
    chk("bypass_lsb_busy", 64'(bus.rs2_busy_out), 0);
    clr();

    // Fill to 16, ignore 17th, wrap tail
    rst_n = 0;
    tick();
    rst_n = 1;
    mtail = '0;
    tick();
    for (int i = 0; i < 16; i++)
      issue(5'(i + 1), 0, 0, 0, 0, 0, 0, 2'd1, 32'h1000 + i);
    chk("full_at16", 64'(bus.full_out), 1);
    chk("tail_wrap0", 64'(bus.tail_idx_out), 0);
    set_iss(5'd30, 0, 0, 0, 0, 1, 32'hBAD);
    tick();
    clr();
    chk("full_after17", 64'(bus.full_out), 1);
    chk("tail_after17", 64'(bus.tail_idx_out), 0);
    alu_wb(4'd0, 32'h1000, 0);
    tick();
    chk("full_commit_pulse", 64'(bus.commit_en_out), 1);
    issue(5'd20, 0, 0, 0, 0, 0, 0, 2'd1, 32'h2000);
    chk("full_refill", 64'(bus.full_out), 1);
    chk("tail_refill", 64'(bus.tail_idx_out), 1);
    for (int i = 1; i < 16; i++) alu_wb(4'(i), 32'h1000 + i, 0);
    alu_wb(4'd0, 32'h2000, 0);
    clr();
    drain(40);

    // Correctly predicted branch reports dest 0
    bidx = mtail;
    issue(5'd0, 1, 0, 1, 32'h200, 0, 0, 2'd1, 32'h5);
    alu_wb(bidx, 32'h5, 1);
    drain(10);

    // Mispredicted branch flushes younger ready entries
    bidx = mtail;
    issue(5'd0, 1, 0, 0, 32'h100, 0, 0, 2'd3, 32'h100);
    issue(5'd4, 0, 0, 0, 0, 1, 32'h44, 2'd0, 0);
    issue(5'd6, 0, 0, 0, 0, 1, 32'h66, 2'd0, 0);
    alu_wb(bidx, 32'h0, 1);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.roll_back_out) begin found = 1; break; end
      tick();
    end
    chk("rb_seen", 64'(found), 1);
    chk("rb_pc", 64'(bus.roll_back_pc_out), 32'h100);
    tick();
    chk("rb_one_pulse", 64'(bus.roll_back_out), 0);
    chk("flush_tail", 64'(bus.tail_idx_out), 0);
    chk("flush_full", 64'(bus.full_out), 0);
    mtail = '0;
    for (int i = 0; i < 4; i++) begin
      chk("flushed_no_commit", 64'(bus.commit_en_out), 0);
      tick();
    end

    // Store retirement
    issue(5'd0, 0, 1, 0, 0, 0, 0, 2'd2, 0);
    bus.lsb_en_in = 1; bus.lsb_idx_in = 4'd0; bus.lsb_val_in = 32'hA0;
    tick();
    clr();
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.store_commit_out) begin found = 1; break; end
      tick();
    end
    chk("store_seen", 64'(found), 1);
    chk("store_idx", 64'(bus.store_commit_idx_out), 0);
    chk("store_no_reg_commit", 64'(bus.commit_en_out), 0);
    drain(5);

    // Freeze with a ready head, release, then async reset mid-stream
    issue(5'd9, 0, 0, 0, 0, 1, 32'h77, 2'd1, 32'h77);
    rdy = 0;
    t = mtail;
    set_iss(5'd7, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_no_commit", 64'(bus.commit_en_out), 0);
      chk("frozen_tail", 64'(bus.tail_idx_out), 64'(t));
    end
    rdy = 1;
    tick();
    clr();
    chk("thaw_commit", 64'(bus.commit_en_out), 1);
    chk("thaw_tail", 64'(bus.tail_idx_out), 64'(t + 4'd1));
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("async_rst_commit_en", 64'(bus.commit_en_out), 0);
    chk("async_rst_commit_val", 64'(bus.commit_val_out), 0);
    chk("async_rst_commit_dest", 64'(bus.commit_dest_out), 0);
    chk("async_rst_tail", 64'(bus.tail_idx_out), 0);
    chk("async_rst_full", 64'(bus.full_out), 0);
    chk("sb_final_empty", 64'(exp_q.size()), 0);
    tick();
    rst_n = 1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
